// File: rtl/obc_dft_pkg.sv
// Shared types and elaboration-time math for the OBC distributed-arithmetic DFT bin engine.
package obc_dft_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} obc_state_e;

    localparam int unsigned TRIG_F = 28;
    localparam longint      ONE_F  = 64'sd268435456;
    localparam longint      PI_F   = 64'sd843314857;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Fixed-point Taylor series on the angle folded into [-pi, pi], rounded half away from zero.
    function automatic longint twiddle(input int unsigned n_pts, input int unsigned k,
                                       input int unsigned n, input int unsigned imag,
                                       input int unsigned coef_w);
        longint p, x, x2, term, acc, den, r, half, res;
        p = longint'((k * n) % n_pts);
        if (p > longint'(n_pts / 2)) p = p - longint'(n_pts);
        x    = (PI_F * p * 64'sd2) / longint'(n_pts);
        x2   = (x * x) >>> TRIG_F;
        term = (imag != 0) ? x : ONE_F;
        acc  = term;
        for (int i = 1; i <= 14; i++) begin
            den  = (imag != 0) ? longint'(2 * i * (2 * i + 1)) : longint'((2 * i - 1) * (2 * i));
            term = -(((term * x2) >>> TRIG_F) / den);
            acc  = acc + term;
        end
        if (imag != 0) acc = -acc;
        r    = acc * (64'sd1 <<< (coef_w - 2));
        half = ONE_F >>> 1;
        res  = (r >= 0) ? ((r + half) >>> TRIG_F) : -(((-r) + half) >>> TRIG_F);
        return res;
    endfunction

    // Address bit j set means sample base+j takes -c; the leading sample always takes +c.
    function automatic longint seg_lut_entry(input int unsigned n_pts, input int unsigned k,
                                             input int unsigned imag, input int unsigned coef_w,
                                             input int unsigned seg, input int unsigned base,
                                             input int unsigned addr);
        longint e, c;
        e = twiddle(n_pts, k, base + seg - 1, imag, coef_w);
        for (int unsigned j = 0; j + 1 < seg; j++) begin
            c = twiddle(n_pts, k, base + j, imag, coef_w);
            e = addr[j] ? (e - c) : (e + c);
        end
        return e;
    endfunction

    function automatic longint csum(input int unsigned n_pts, input int unsigned k,
                                    input int unsigned imag, input int unsigned coef_w);
        longint s;
        s = 0;
        for (int unsigned n = 0; n < n_pts; n++) s = s + twiddle(n_pts, k, n, imag, coef_w);
        return s;
    endfunction

endpackage

// File: rtl/obc_da_bin_serial_if.sv
// Sample-vector input and result output handshakes of the OBC DFT bin engine.
interface obc_da_bin_serial_if #(
    parameter int unsigned N_PTS  = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 40
);
    logic                      in_valid;
    logic                      in_ready;
    logic [N_PTS*DATA_W-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [ACC_W-1:0]   out_data;

    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/obc_seg_lut.sv
// One sign-symmetric partial-sum LUT covering SEG consecutive samples of a bit slice.
module obc_seg_lut
    import obc_dft_pkg::*;
#(
    parameter int unsigned SEG    = 2,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned BIN_K  = 9,
    parameter int unsigned IMAG   = 1,
    parameter int unsigned N_PTS  = 16,
    parameter int unsigned BASE   = 0,
    parameter int unsigned OUT_W  = 40
) (
    input  logic [SEG-1:0]          bits_i,
    input  logic                    msb_i,
    output logic signed [OUT_W-1:0] part_c_o
);
    localparam int unsigned N_ENT = 1 << (SEG - 1);
    localparam int unsigned AW    = (SEG > 1) ? SEG - 1 : 1;

    logic signed [OUT_W-1:0] lut_c [N_ENT];
    logic [AW-1:0]           addr_c;
    logic                    lead_c;

    for (genvar a = 0; a < N_ENT; a++) begin : g_ent
        assign lut_c[a] = OUT_W'(seg_lut_entry(N_PTS, BIN_K, IMAG, COEF_W, SEG, BASE, a));
    end

    assign lead_c = bits_i[SEG-1];

    always_comb begin
        addr_c = '0;
        for (int j = 0; j < int'(SEG) - 1; j++) addr_c[j] = bits_i[j] ^ lead_c;
    end

    // Entries assume a set leading bit; a clear one mirrors the sum, and the MSB slice flips it again.
    always_comb begin
        part_c_o = lut_c[addr_c];
        if ((~lead_c) ^ msb_i) part_c_o = -lut_c[addr_c];
    end
endmodule

// File: rtl/obc_da_bin_serial.sv
// Bit-serial OBC distributed-arithmetic engine producing one DFT bin component sum(c[n]*x[n]).
module obc_da_bin_serial
    import obc_dft_pkg::*;
#(
    parameter int unsigned N_PTS  = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned SEG    = 2,
    parameter int unsigned BIN_K  = 9,
    parameter int unsigned IMAG   = 1,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    obc_da_bin_serial_if.slave   bus,
    output logic                 busy
);
    localparam int unsigned N_SEG   = N_PTS / SEG;
    localparam int unsigned VEC_W   = N_PTS * DATA_W;
    localparam int unsigned CNT_W   = clog2(DATA_W + 1);
    localparam int unsigned ACC_MIN = DATA_W + COEF_W + clog2(N_PTS) + 2;

    if (ACC_W < ACC_MIN) begin : g_bad_acc_w
        $error("obc_da_bin_serial: ACC_W is too narrow for full-scale inputs");
    end
    if ((N_PTS % SEG) != 0) begin : g_bad_seg
        $error("obc_da_bin_serial: SEG must divide N_PTS");
    end

    obc_state_e              state_q, state_d;
    logic [VEC_W-1:0]        data_q, data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, busy_q;

    logic [N_PTS-1:0]        slice_c;
    logic                    msb_c;
    logic signed [ACC_W-1:0] part_c [N_SEG];
    logic signed [ACC_W-1:0] t_c, csum_c, diff_c;

    always_comb begin
        slice_c = '0;
        for (int n = 0; n < int'(N_PTS); n++) slice_c[n] = data_q[n*DATA_W];
    end

    assign msb_c  = (cnt_q == CNT_W'(DATA_W - 1));
    assign csum_c = ACC_W'(csum(N_PTS, BIN_K, IMAG, COEF_W));
    assign diff_c = acc_q - csum_c;

    for (genvar s = 0; s < N_SEG; s++) begin : g_seg
        obc_seg_lut #(
            .SEG(SEG), .COEF_W(COEF_W), .BIN_K(BIN_K), .IMAG(IMAG),
            .N_PTS(N_PTS), .BASE(s * SEG), .OUT_W(ACC_W)
        ) u_seg (
            .bits_i   (slice_c[s*SEG +: SEG]),
            .msb_i    (msb_c),
            .part_c_o (part_c[s])
        );
    end

    always_comb begin
        t_c = '0;
        for (int s = 0; s < int'(N_SEG); s++) t_c = t_c + part_c[s];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    data_d  = bus.in_data;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + (t_c <<< cnt_q);
                for (int n = 0; n < int'(N_PTS); n++)
                    data_d[n*DATA_W +: DATA_W] = {1'b0, data_q[n*DATA_W+1 +: DATA_W-1]};
                cnt_d = cnt_q + 1'b1;
                if (msb_c) state_d = FIN;
            end
            FIN: begin
                out_data_d  = diff_c >>> 1;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_obc_da_bin_serial.sv
// Directed and randomised checks of the OBC DFT bin engine in three configurations.
module tb_obc_da_bin_serial;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // round(-16384*sin(2*pi*9*n/16)) and round(16384*cos(2*pi*3*n/8))
    localparam int CA [16] = '{0, 6270, -11585, 15137, -16384, 15137, -11585, 6270,
                               0, -6270, 11585, -15137, 16384, -15137, 11585, -6270};
    localparam int CB [8]  = '{16384, -11585, 0, 11585, -16384, 11585, 0, -11585};

    logic busy_a, busy_b, busy_c;

    obc_da_bin_serial_if #(.N_PTS(16), .DATA_W(16), .ACC_W(40)) bus_a ();
    obc_da_bin_serial_if #(.N_PTS(8),  .DATA_W(12), .ACC_W(40)) bus_b ();
    obc_da_bin_serial_if #(.N_PTS(16), .DATA_W(16), .ACC_W(40)) bus_c ();

    obc_da_bin_serial u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a), .busy(busy_a));
    obc_da_bin_serial #(.N_PTS(8), .DATA_W(12), .COEF_W(16), .SEG(4), .BIN_K(3), .IMAG(0), .ACC_W(40))
        u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b), .busy(busy_b));
    obc_da_bin_serial #(.BIN_K(0), .IMAG(0))
        u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c), .busy(busy_c));

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    function automatic longint gold_a(input logic [255:0] v);
        longint s = 0;
        for (int n = 0; n < 16; n++) s += longint'(CA[n]) * longint'($signed(v[n*16 +: 16]));
        return s;
    endfunction

    function automatic longint gold_b(input logic [95:0] v);
        longint s = 0;
        for (int n = 0; n < 8; n++) s += longint'(CB[n]) * longint'($signed(v[n*12 +: 12]));
        return s;
    endfunction

    function automatic logic [255:0] fill16(input logic [15:0] x);
        logic [255:0] v;
        for (int n = 0; n < 16; n++) v[n*16 +: 16] = x;
        return v;
    endfunction

    // Called and returns on a falling edge; noise drives junk in_valid/out_ready while busy.
    task automatic xact_a(input logic [255:0] vec, input int hold, input bit noise,
                          output logic signed [39:0] res, output int lat);
        int  w;
        bit  ok;
        bus_a.in_data  = vec;
        bus_a.in_valid = 1'b1;
        w = 0;
        while (!bus_a.in_ready && w < 50) begin @(negedge clk); w++; end
        check("accept_a", 64'(bus_a.in_ready), 64'd1);
        @(negedge clk);
        bus_a.in_valid = noise;
        bus_a.in_data  = ~vec;
        lat = 0;
        while (!bus_a.out_valid && lat < 50) begin
            bus_a.out_ready = noise && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            lat++;
        end
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b0;
        res = bus_a.out_data;
        ok  = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus_a.out_data !== res || bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0) ok = 1'b0;
        end
        if (hold > 0) check("hold_a", 64'(ok), 64'd1);
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        bus_a.out_ready = 1'b0;
        check("drop_a", 64'(bus_a.out_valid), 64'd0);
    endtask

    task automatic xact_b(input logic [95:0] vec, output logic signed [39:0] res);
        int w;
        bus_b.in_data  = vec;
        bus_b.in_valid = 1'b1;
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        w = 0;
        while (!bus_b.out_valid && w < 50) begin @(negedge clk); w++; end
        res = bus_b.out_data;
        bus_b.out_ready = 1'b1;
        @(negedge clk);
        bus_b.out_ready = 1'b0;
    endtask

    task automatic xact_c(input logic [255:0] vec, output logic signed [39:0] res);
        int w;
        bus_c.in_data  = vec;
        bus_c.in_valid = 1'b1;
        @(negedge clk);
        bus_c.in_valid = 1'b0;
        w = 0;
        while (!bus_c.out_valid && w < 50) begin @(negedge clk); w++; end
        res = bus_c.out_data;
        bus_c.out_ready = 1'b1;
        @(negedge clk);
        bus_c.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0]        v;
        logic [95:0]         vb;
        logic signed [39:0]  res;
        int                  lat;
        bit                  saw;

        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
        bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(bus_a.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_out_data",  64'(bus_a.out_data),  64'd0);
        check("rst_busy",      64'(busy_a),          64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        v = '0; v[16 +: 16] = 16'd1;
        xact_a(v, 3, 1'b0, res, lat);
        check("x1_one", 64'(res), 64'sd6270);
        check("latency", 64'(lat), 64'd17);

        v = '0; v[16 +: 16] = 16'h8000;
        xact_a(v, 2, 1'b0, res, lat);
        check("x1_min", 64'(res), -64'sd205455360);

        xact_a(fill16(16'h0000), 0, 1'b0, res, lat);
        check("all_zero", 64'(res), 64'sd0);
        xact_a(fill16(16'h0001), 0, 1'b0, res, lat);
        check("all_one", 64'(res), 64'sd0);
        xact_a(fill16(16'h8000), 0, 1'b0, res, lat);
        check("all_min", 64'(res), 64'sd0);

        for (int n = 0; n < 16; n++) v[n*16 +: 16] = 16'(n);
        xact_a(v, 1, 1'b0, res, lat);
        check("ramp", 64'(res), -64'sd26080);

        // Abort during the bit-7 slice, then confirm nothing leaks into the next vector.
        v = '0; v[16 +: 16] = 16'h7fff;
        bus_a.in_data = v; bus_a.in_valid = 1'b1;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        check("busy_run", 64'(busy_a), 64'd1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  64'(bus_a.in_ready),  64'd1);
        check("abort_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("abort_out_data",  64'(bus_a.out_data),  64'd0);
        check("abort_busy",      64'(busy_a),          64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (25) begin @(negedge clk); if (bus_a.out_valid) saw = 1'b1; end
        check("abort_no_out", 64'(saw), 64'd0);
        v = '0; v[16 +: 16] = 16'd1;
        xact_a(v, 0, 1'b0, res, lat);
        check("after_abort", 64'(res), 64'sd6270);

        for (int i = 0; i < 200; i++) begin
            for (int n = 0; n < 16; n++) v[n*16 +: 16] = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xact_a(v, int'($urandom_range(0, 4)), 1'b1, res, lat);
            check("rand_a", 64'(res), gold_a(v));
            check("rand_lat", 64'(lat), 64'd17);
        end

        vb = '0; vb[11:0] = 12'h800;
        xact_b(vb, res);
        check("b_x0_min", 64'(res), -64'sd33554432);
        for (int n = 0; n < 8; n++) vb[n*12 +: 12] = 12'h800;
        xact_b(vb, res);
        check("b_all_min", 64'(res), 64'sd0);
        vb = '0; vb[36 +: 12] = 12'd1;
        xact_b(vb, res);
        check("b_x3_one", 64'(res), 64'sd11585);
        for (int i = 0; i < 20; i++) begin
            for (int n = 0; n < 8; n++) vb[n*12 +: 12] = 12'($urandom);
            xact_b(vb, res);
            check("rand_b", 64'(res), gold_b(vb));
        end

        xact_c(fill16(16'h0001), res);
        check("c_all_one", 64'(res), 64'sd262144);
        xact_c(fill16(16'h8000), res);
        check("c_all_min", 64'(res), -64'sd8589934592);
        v = '0; v[80 +: 16] = 16'd100;
        xact_c(v, res);
        check("c_x5", 64'(res), 64'sd1638400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
